// File: rtl/ldp_emu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ldp_emu_pkg
// Brief    : Shared state encoding, widths and descriptor type for the LDP
//            emulator frame path.
// Revision : 1.0
// ============================================================================
package ldp_emu_pkg;

    localparam int ADDR_W    = 64;
    localparam int CFG_W     = 32;
    localparam int FNUM_W    = 32;
    localparam int CREDIT_W  = 34;
    localparam int FCOUNT_W  = 64;

    localparam int C_MD_BYTES_DEF = 64;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_RUN   = 2'd1;
    localparam logic [1:0] C_ST_ISSUE = 2'd2;

    typedef struct packed {
        logic              side;
        logic [ADDR_W-1:0] fd_addr;
        logic [ADDR_W-1:0] md_addr;
        logic [ADDR_W-1:0] fc_addr;
        logic [FNUM_W-1:0] frame_num;
    } desc_t;

endpackage
`default_nettype wire

// File: rtl/ldp_rate_credit.sv
`default_nettype none
// ============================================================================
// Module   : ldp_rate_credit
// Brief    : Microsecond tick counter and saturating byte-credit accumulator.
// Revision : 1.0
// ============================================================================
module ldp_rate_credit
    import ldp_emu_pkg::*;
#(
    parameter int CLKS_PER_USEC = 250
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clr,
    input  logic                add_en,
    input  logic                take,
    input  logic [CFG_W-1:0]    rate,
    input  logic [CFG_W-1:0]    frame_size,
    output logic [CREDIT_W-1:0] credit
);

    localparam int TICK_W = (CLKS_PER_USEC > 1) ? $clog2(CLKS_PER_USEC) : 1;
    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(CLKS_PER_USEC - 1);

    logic [TICK_W-1:0]   r_tick;
    logic [CREDIT_W-1:0] r_credit;
    logic                w_tc;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_cap;

    assign w_tc  = add_en && (r_tick == C_TICK_LAST);
    assign w_cap = {2'b00, frame_size, 1'b0};

    // take is only raised with credit >= frame_size, so the subtraction never underflows
    assign w_sum = {1'b0, r_credit}
                 - (take ? {3'b000, frame_size} : {(CREDIT_W+1){1'b0}})
                 + (w_tc ? {3'b000, rate}       : {(CREDIT_W+1){1'b0}});

    always_ff @(posedge clk) begin
        if (!resetn || !add_en) begin
            r_tick <= '0;
        end else if (w_tc) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            r_credit <= '0;
        end else if (w_sum > w_cap) begin
            r_credit <= w_cap[CREDIT_W-1:0];
        end else begin
            r_credit <= w_sum[CREDIT_W-1:0];
        end
    end

    assign credit = r_credit;

endmodule
`default_nettype wire

// File: rtl/ldp_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ldp_frame_sequencer
// Brief    : Rate-paced frame descriptor generator alternating between two
//            ring sides (frame data, metadata and frame-counter addresses).
// Revision : 1.0
// ============================================================================
module ldp_frame_sequencer
    import ldp_emu_pkg::*;
#(
    parameter int CLKS_PER_USEC = 250,
    parameter int MD_BYTES      = C_MD_BYTES_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic [CFG_W-1:0]    FRAME_SIZE,
    input  logic [CFG_W-1:0]    BYTES_PER_USEC,
    input  logic [ADDR_W-1:0]   FD0_RING_ADDR,
    input  logic [ADDR_W-1:0]   FD1_RING_ADDR,
    input  logic [ADDR_W-1:0]   FD_RING_SIZE,
    input  logic [ADDR_W-1:0]   MD0_RING_ADDR,
    input  logic [ADDR_W-1:0]   MD1_RING_ADDR,
    input  logic [ADDR_W-1:0]   MD_RING_SIZE,
    input  logic [ADDR_W-1:0]   FC0_ADDR,
    input  logic [ADDR_W-1:0]   FC1_ADDR,
    output logic                desc_valid,
    input  logic                desc_ready,
    output logic                desc_side,
    output logic [ADDR_W-1:0]   desc_fd_addr,
    output logic [ADDR_W-1:0]   desc_md_addr,
    output logic [ADDR_W-1:0]   desc_fc_addr,
    output logic [FNUM_W-1:0]   desc_frame_num,
    output logic                running,
    output logic                cfg_error,
    output logic [FCOUNT_W-1:0] frames_issued
);

    localparam logic [ADDR_W-1:0] C_MD_STEP = ADDR_W'(MD_BYTES);

    logic [1:0]          r_state;
    logic                r_cfg_error;
    logic                r_stop_pending;
    logic                r_side;
    logic [CFG_W-1:0]    r_fs;
    logic [CFG_W-1:0]    r_bpu;
    logic [ADDR_W-1:0]   r_fd_base [2];
    logic [ADDR_W-1:0]   r_md_base [2];
    logic [ADDR_W-1:0]   r_fc_addr [2];
    logic [ADDR_W-1:0]   r_fd_size;
    logic [ADDR_W-1:0]   r_md_size;
    logic [ADDR_W-1:0]   r_fd_off  [2];
    logic [ADDR_W-1:0]   r_md_off  [2];
    logic [FNUM_W-1:0]   r_cnt     [2];
    logic [FCOUNT_W-1:0] r_frames;
    desc_t               r_desc;

    logic                w_cfg_bad;
    logic                w_start_ok;
    logic                w_take;
    logic                w_hs;
    logic                w_add_en;
    logic [CREDIT_W-1:0] w_credit;
    logic [ADDR_W-1:0]   w_fs64;
    logic [ADDR_W-1:0]   w_fd_next;
    logic [ADDR_W-1:0]   w_md_next;
    logic                w_fd_wrap;
    logic                w_md_wrap;

    assign w_cfg_bad = (FRAME_SIZE == '0) || (BYTES_PER_USEC == '0)
                    || (FD_RING_SIZE < {32'b0, FRAME_SIZE})
                    || (MD_RING_SIZE < C_MD_STEP);

    assign w_start_ok = (r_state == C_ST_IDLE) && start && !w_cfg_bad;
    assign w_add_en   = (r_state != C_ST_IDLE);
    assign w_take     = (r_state == C_ST_RUN) && !stop
                     && (w_credit >= {2'b00, r_fs});
    assign w_hs       = (r_state == C_ST_ISSUE) && desc_ready;

    // Wrap when the next frame would not fit entirely inside the ring
    assign w_fs64    = {32'b0, r_fs};
    assign w_fd_next = r_fd_off[r_side] + w_fs64;
    assign w_md_next = r_md_off[r_side] + C_MD_STEP;
    assign w_fd_wrap = ({1'b0, w_fd_next} + {1'b0, w_fs64})    > {1'b0, r_fd_size};
    assign w_md_wrap = ({1'b0, w_md_next} + {1'b0, C_MD_STEP}) > {1'b0, r_md_size};

    ldp_rate_credit #(
        .CLKS_PER_USEC (CLKS_PER_USEC)
    ) u_rate_credit (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (w_start_ok),
        .add_en     (w_add_en),
        .take       (w_take),
        .rate       (r_bpu),
        .frame_size (r_fs),
        .credit     (w_credit)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= C_ST_IDLE;
            r_cfg_error    <= 1'b0;
            r_stop_pending <= 1'b0;
            r_side         <= 1'b0;
            r_fs           <= '0;
            r_bpu          <= '0;
            r_fd_base[0]   <= '0;
            r_fd_base[1]   <= '0;
            r_md_base[0]   <= '0;
            r_md_base[1]   <= '0;
            r_fc_addr[0]   <= '0;
            r_fc_addr[1]   <= '0;
            r_fd_size      <= '0;
            r_md_size      <= '0;
            r_fd_off[0]    <= '0;
            r_fd_off[1]    <= '0;
            r_md_off[0]    <= '0;
            r_md_off[1]    <= '0;
            r_cnt[0]       <= '0;
            r_cnt[1]       <= '0;
            r_frames       <= '0;
            r_desc         <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (start && w_cfg_bad) begin
                        r_cfg_error <= 1'b1;
                    end else if (w_start_ok) begin
                        r_cfg_error    <= 1'b0;
                        r_stop_pending <= 1'b0;
                        r_side         <= 1'b0;
                        r_fs           <= FRAME_SIZE;
                        r_bpu          <= BYTES_PER_USEC;
                        r_fd_base[0]   <= FD0_RING_ADDR;
                        r_fd_base[1]   <= FD1_RING_ADDR;
                        r_md_base[0]   <= MD0_RING_ADDR;
                        r_md_base[1]   <= MD1_RING_ADDR;
                        r_fc_addr[0]   <= FC0_ADDR;
                        r_fc_addr[1]   <= FC1_ADDR;
                        r_fd_size      <= FD_RING_SIZE;
                        r_md_size      <= MD_RING_SIZE;
                        r_fd_off[0]    <= '0;
                        r_fd_off[1]    <= '0;
                        r_md_off[0]    <= '0;
                        r_md_off[1]    <= '0;
                        r_cnt[0]       <= '0;
                        r_cnt[1]       <= '0;
                        r_frames       <= '0;
                        r_state        <= C_ST_RUN;
                    end
                end
                C_ST_RUN: begin
                    if (stop) begin
                        r_state <= C_ST_IDLE;
                    end else if (w_take) begin
                        r_desc.side      <= r_side;
                        r_desc.fd_addr   <= r_fd_base[r_side] + r_fd_off[r_side];
                        r_desc.md_addr   <= r_md_base[r_side] + r_md_off[r_side];
                        r_desc.fc_addr   <= r_fc_addr[r_side];
                        r_desc.frame_num <= r_cnt[r_side] + 1'b1;
                        r_state          <= C_ST_ISSUE;
                    end
                end
                C_ST_ISSUE: begin
                    if (w_hs) begin
                        r_cnt[r_side]    <= r_cnt[r_side] + 1'b1;
                        r_frames         <= r_frames + 1'b1;
                        r_fd_off[r_side] <= w_fd_wrap ? '0 : w_fd_next;
                        r_md_off[r_side] <= w_md_wrap ? '0 : w_md_next;
                        r_side           <= ~r_side;
                        r_stop_pending   <= 1'b0;
                        r_state          <= (r_stop_pending || stop) ? C_ST_IDLE : C_ST_RUN;
                    end else if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign desc_valid     = (r_state == C_ST_ISSUE);
    assign desc_side      = r_desc.side;
    assign desc_fd_addr   = r_desc.fd_addr;
    assign desc_md_addr   = r_desc.md_addr;
    assign desc_fc_addr   = r_desc.fc_addr;
    assign desc_frame_num = r_desc.frame_num;
    assign running        = (r_state != C_ST_IDLE);
    assign cfg_error      = r_cfg_error;
    assign frames_issued  = r_frames;

endmodule
`default_nettype wire

// File: doc/ldp_frame_sequencer.md
# ldp_frame_sequencer

Paces frame emission for the LDP emulator and produces one write descriptor per frame: frame-data address, metadata address, frame-counter address and frame number. It sits directly downstream of the LDP configuration register block, consuming FRAME_SIZE, BYTES_PER_USEC and the ring and counter addresses. It feeds the DMA/packet-builder stage through a valid/ready descriptor handshake. Frames alternate between side 0 and side 1, each side with its own ring write pointers.

## Interface
Parameters:
- CLKS_PER_USEC, 250: clk cycles per microsecond (rate tick period).
- MD_BYTES, 64: metadata record size in bytes (512-bit METADATA).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  pulse: latch config, clear pointers and counters, begin running.
- stop  in  1  pulse: cease issuing after any in-flight descriptor completes.
- FRAME_SIZE  in  32  bytes per frame.
- BYTES_PER_USEC  in  32  emulated data rate.
- FD0_RING_ADDR, FD1_RING_ADDR, FD_RING_SIZE  in  64 each  frame-data ring bases and size.
- MD0_RING_ADDR, MD1_RING_ADDR, MD_RING_SIZE  in  64 each  metadata ring bases and size.
- FC0_ADDR, FC1_ADDR  in  64 each  frame-counter locations.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  consumer accepts.
- desc_side  out  1  side of this frame.
- desc_fd_addr, desc_md_addr, desc_fc_addr  out  64 each  target addresses.
- desc_frame_num  out  32  per-side frame count including this frame (starts at 1).
- running  out  1  sequencer active.
- cfg_error  out  1  sticky: last start rejected.
- frames_issued  out  64  descriptors accepted since start.

## Operation
- States: IDLE, RUN, ISSUE.
- IDLE: on start, validate the inputs. Rejection criteria: FRAME_SIZE==0, BYTES_PER_USEC==0, FD_RING_SIZE<FRAME_SIZE, or MD_RING_SIZE<MD_BYTES.
  - If rejected: set cfg_error=1 and stay in IDLE.
  - Otherwise: clear cfg_error, latch all config into shadow registers, zero credit, offsets, per-side counts and frames_issued, set side=0, and go to RUN.
- Tick counter: counts 0..CLKS_PER_USEC-1 while not IDLE. At the terminal count, credit += BYTES_PER_USEC.
  - credit is 34 bits and saturates at 2*FRAME_SIZE.
  - Credit keeps accumulating in ISSUE.
- RUN: when credit >= FRAME_SIZE, go to ISSUE, subtract FRAME_SIZE from credit, and register the descriptor:
  - fd = FDs_BASE + fd_off[s]
  - md = MDs_BASE + md_off[s]
  - fc = FCs_ADDR
  - frame_num = count[s]+1
- ISSUE: hold desc_valid=1 with stable fields until desc_ready. On the handshake:
  - count[s]++ and frames_issued++.
  - fd_off[s] += FRAME_SIZE; if the new fd_off[s]+FRAME_SIZE > FD_RING_SIZE, set it to 0.
  - md_off[s] += MD_BYTES, with the same wrap rule against MD_RING_SIZE.
  - side toggles.
  - Return to RUN, or to IDLE if stop is pending.
- stop:
  - In RUN: go to IDLE next cycle.
  - In ISSUE: set stop_pending; the current descriptor still completes.
  - In IDLE: ignored.
- start while not IDLE is ignored.
- Config inputs changing while running have no effect until the next start.

## Timing
- Reset values: every output 0; state IDLE; credit, offsets and counters 0.
- start to running=1: 1 cycle.
- Credit crossing FRAME_SIZE to desc_valid=1: 1 cycle. Credit is updated in the same cycle as the crossing.
- Handshake: the descriptor transfers on the cycle where desc_valid and desc_ready are both 1. The next descriptor has desc_valid=1 no earlier than 2 cycles later.
- desc_ready is permitted to be high before desc_valid.
- Offset update and side toggle are visible on the cycle after the handshake.
- Tick terminal count and handshake in the same cycle: both the credit add and the state update occur.
- Reset mid-operation: all state cleared at once; desc_valid drops on the next edge.
- 64-bit address adds wrap modulo 2^64. No carry check is performed.

## Structure
- Shared package ldp_emu_pkg holds:
  - state encoding (IDLE/RUN/ISSUE);
  - MD_BYTES default;
  - descriptor field widths.
- One sub-module: ldp_rate_credit (tick counter plus saturating credit accumulator, with ports add_en and take). All remaining logic stays in the top level.

## Test plan
- Reset then start with FRAME_SIZE=0 -> cfg_error=1, running=0, desc_valid never asserts.
- Settings CLKS_PER_USEC=4, BYTES_PER_USEC=256, FRAME_SIZE=1024, desc_ready tied high -> a descriptor every 16 cycles (±1); sides 0,1,0,1; frame_num 1,1,2,2.
- FD_RING_SIZE=3072, FRAME_SIZE=1024, FD0_RING_ADDR=0x1000 -> side-0 fd addresses 0x1000,0x1400,0x1800,0x1000; md addresses step by 0x40.
- desc_ready held low 200 cycles -> fields stable, credit capped at 2048; on release, two descriptors issue back-to-back (second 2 cycles after the first).
- stop asserted while desc_valid=1 -> that descriptor completes on desc_ready, then running=0 and no further valid.
- resetn low during ISSUE -> next cycle desc_valid=0 and frames_issued=0; a following start resumes at side 0, offset 0.
